// File: rtl/regfile_dump.sv
// ----------------------------------------------------------------------------
// regfile_dump
//
// Debug read-out engine for the general-purpose register file. On a start
// request it asks ctrl to halt the pipeline. Once the pipeline is halted it
// walks the register file's second read port from START_ADDR to END_ADDR and
// streams each register value out over a valid/ready interface to the
// debug/UART bridge.
//
// Optional feature macro: DUMP_CHECKSUM_EN
//   defined   : one extra trailing beat that carries the XOR of every dumped
//               value (dump_csum=1, dump_last=1 on that beat).
//   undefined : no checksum state or register; dump_last marks the END_ADDR beat.
//
// Ports
//   clk, rst     : clock and synchronous active-high reset
//   start, abort : begin a dump (taken only when idle) / cancel a dump
//   halted       : pipeline frozen and WB drained (from ctrl)
//   stallreq     : pipeline hold request to ctrl
//   re, raddr    : register file read enable / address (second read port)
//   rdata        : register file read data, same-cycle combinational
//   dump_valid, dump_ready                     : output beat handshake
//   dump_addr, dump_data, dump_csum, dump_last : output beat payload
//   busy, done   : engine not idle / one-cycle pulse on normal completion
// ----------------------------------------------------------------------------
module regfile_dump #(
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        halted,
    output logic        stallreq,
    output logic        re,
    output logic [4:0]  raddr,
    input  logic [31:0] rdata,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [4:0]  dump_addr,
    output logic [31:0] dump_data,
    output logic        dump_csum,
    output logic        dump_last,
    output logic        busy,
    output logic        done
);

    localparam logic        ReadEnable  = 1'b1;
    localparam logic        ReadDisable = 1'b0;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    localparam logic [4:0] START_PTR = 5'(START_ADDR);
    localparam logic [4:0] END_PTR   = 5'(END_ADDR);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] READ = 3'd2;
    localparam logic [2:0] SEND = 3'd3;
`ifdef DUMP_CHECKSUM_EN
    localparam logic [2:0] CSUM = 3'd4;
`endif
    localparam logic [2:0] DONE = 3'd5;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [4:0]  ptr;
    logic [4:0]  addr_q;
    logic [31:0] data_q;
    logic        last_q;
`ifdef DUMP_CHECKSUM_EN
    logic [31:0] csum_q;
`endif

    logic read_active;
    logic capture;
    logic handshake;
    logic at_end;

    // The read port is only driven while we own it: in READ with the
    // pipeline confirmed halted.
    assign read_active = (state == READ) && halted;
    assign capture     = read_active && !abort;
    assign handshake   = dump_valid && dump_ready;
    // Compare before increment so END_ADDR=31 ends without the pointer wrapping.
    assign at_end      = (ptr == END_PTR);

    assign re        = read_active ? ReadEnable : ReadDisable;
    assign raddr     = read_active ? ptr : 5'd0;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign stallreq  = (state != IDLE) && (state != DONE);
    assign dump_addr = addr_q;
    assign dump_data = data_q;
    assign dump_last = last_q;
`ifdef DUMP_CHECKSUM_EN
    assign dump_valid = (state == SEND) || (state == CSUM);
    assign dump_csum  = (state == CSUM);
`else
    assign dump_valid = (state == SEND);
    assign dump_csum  = 1'b0;
`endif

    // Next-state decode. Abort overrides everything, including a start
    // request seen in IDLE.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (start)  state_next = REQ;
                REQ:  if (halted) state_next = READ;
                READ: if (halted) state_next = SEND;
                SEND: begin
                    if (handshake) begin
                        if (at_end) begin
`ifdef DUMP_CHECKSUM_EN
                            state_next = CSUM;
`else
                            state_next = DONE;
`endif
                        end else begin
                            state_next = READ;
                        end
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                CSUM: if (handshake) state_next = DONE;
`endif
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // State, pointer and beat registers. The beat payload is written only on
    // capture (and on entry to the checksum beat), so it holds steady while
    // the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= 5'd0;
            addr_q <= 5'd0;
            data_q <= ZeroWord;
            last_q <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum_q <= ZeroWord;
`endif
        end else begin
            state <= state_next;
            if ((state == IDLE) && start && !abort) begin
                ptr <= START_PTR;
`ifdef DUMP_CHECKSUM_EN
                csum_q <= ZeroWord;
`endif
            end
            if (capture) begin
                data_q <= rdata;
                addr_q <= ptr;
`ifdef DUMP_CHECKSUM_EN
                last_q <= 1'b0;
                csum_q <= csum_q ^ rdata;
`else
                last_q <= at_end;
`endif
            end
            if ((state == SEND) && handshake && !abort) begin
                if (!at_end) begin
                    ptr <= ptr + 5'd1;
                end
`ifdef DUMP_CHECKSUM_EN
                else begin
                    data_q <= csum_q;
                    addr_q <= 5'd0;
                    last_q <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// ----------------------------------------------------------------------------
// tb_regfile_dump
//
// Scoreboard bench for regfile_dump. Starting a dump pushes the whole
// expected beat sequence (derived from the register array) into a queue; a
// negedge monitor pops and compares on every accepted beat, and also checks
// beat stability under back-pressure and that the read port is idle while
// the pipeline is not halted. A second instance covers a one-register range.
// ----------------------------------------------------------------------------
module tb_regfile_dump;

`ifdef DUMP_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
        logic        csum;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst, start, abort, halted, dump_ready;
    logic        stallreq, re, dump_valid, dump_csum, dump_last, busy, done;
    logic [4:0]  raddr, dump_addr;
    logic [31:0] rdata, dump_data;

    logic        start1;
    logic        stallreq1, re1, dump_valid1, dump_csum1, dump_last1, busy1, done1;
    logic [4:0]  raddr1, dump_addr1;
    logic [31:0] rdata1, dump_data1;

    logic [31:0] regs [32];
    beat_t       expq [$];

    int vectors = 0;
    int miscompares = 0;
    int doneSeen = 0;
    int doneExpected = 0;

    bit        randReady = 1'b0;
    bit        randHalt = 1'b0;
    bit        haltLevel = 1'b1;
    bit        forceReadyLow = 1'b0;
    int        readyHoldCnt = 0;
    logic [4:0] readyHoldAddr = 5'd0;
    int        dropCnt = 0;
    bit        dropActive = 1'b0;
    logic [4:0] dropAddr = 5'd0;

    logic        holdPrev = 1'b0;
    logic [38:0] heldVal = '0;

    always #5 clk = ~clk;

    // Register file model: combinational read of the array.
    assign rdata  = regs[raddr];
    assign rdata1 = regs[raddr1];

    regfile_dump #(.START_ADDR(0), .END_ADDR(31)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .halted(halted),
        .stallreq(stallreq), .re(re), .raddr(raddr), .rdata(rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
        .dump_data(dump_data), .dump_csum(dump_csum), .dump_last(dump_last),
        .busy(busy), .done(done)
    );

    regfile_dump #(.START_ADDR(31), .END_ADDR(31)) dutOne (
        .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .halted(1'b1),
        .stallreq(stallreq1), .re(re1), .raddr(raddr1), .rdata(rdata1),
        .dump_valid(dump_valid1), .dump_ready(1'b1), .dump_addr(dump_addr1),
        .dump_data(dump_data1), .dump_csum(dump_csum1), .dump_last(dump_last1),
        .busy(busy1), .done(done1)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Advance one clock, then drive halted/dump_ready according to the
    // currently selected modes.
    task automatic tick();
        @(posedge clk);
        #1;
        if (readyHoldCnt > 0 && dump_valid && dump_addr == readyHoldAddr) begin
            dump_ready = 1'b0;
            readyHoldCnt--;
        end else if (forceReadyLow) begin
            dump_ready = 1'b0;
        end else begin
            dump_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (dropActive) begin
            halted = 1'b0;
            dropCnt--;
            if (dropCnt == 0) dropActive = 1'b0;
        end else if (dropCnt > 0 && re && raddr == dropAddr) begin
            halted = 1'b0;
            dropActive = 1'b1;
            dropCnt--;
        end else begin
            halted = randHalt ? ($urandom_range(0, 3) != 0) : haltLevel;
        end
    endtask

    // Expected beats for a full dump of the main instance, from the array.
    task automatic issueDump();
        beat_t       b;
        logic [31:0] x;
        x = 32'h0;
        for (int a = 0; a <= 31; a++) begin
            b.addr = 5'(a);
            b.data = regs[a];
            b.last = !CSUM_ON && (a == 31);
            b.csum = 1'b0;
            x = x ^ regs[a];
            expq.push_back(b);
        end
        if (CSUM_ON) begin
            b.addr = 5'd0;
            b.data = x;
            b.last = 1'b1;
            b.csum = 1'b1;
            expq.push_back(b);
        end
        doneExpected++;
    endtask

    task automatic applyStimulus();
        start = 1'b1;
        issueDump();
        tick();
        start = 1'b0;
    endtask

    task automatic runToDone(output int cyc);
        cyc = 1;
        while (!done && cyc < 3000) begin
            tick();
            cyc++;
        end
        checkOutput("done reached", 64'(done), 64'(1));
        checkOutput("queue drained", 64'(expq.size()), 64'(0));
    endtask

    task automatic randomRegs();
        regs[0] = 32'h0;
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        beat_t b;
        if (!rst) begin
            if (dump_valid && dump_ready) begin
                checkOutput("beat expected", 64'(expq.size() != 0), 64'(1));
                if (expq.size() != 0) begin
                    b = expq.pop_front();
                    checkOutput("beat", 64'({dump_addr, dump_data, dump_last, dump_csum}), 64'(b));
                end
            end
            if (holdPrev)
                checkOutput("held beat", 64'({dump_valid, dump_addr, dump_data, dump_last}), 64'(heldVal));
            if (!halted)
                checkOutput("read port idle", 64'({re, raddr}), 64'(0));
            if (done) doneSeen <= doneSeen + 1;
            holdPrev <= dump_valid && !dump_ready && !abort;
            heldVal  <= {dump_valid, dump_addr, dump_data, dump_last};
        end else begin
            holdPrev <= 1'b0;
        end
    end

    initial begin
        int cyc;
        int cnt;
        int doneBefore;

        rst = 1'b1; start = 1'b0; start1 = 1'b0; abort = 1'b0;
        halted = 1'b1; dump_ready = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h0101_0101;
        tick();
        tick();
        checkOutput("reset outputs", 64'({stallreq, re, raddr, dump_valid, dump_addr, dump_data,
                    dump_csum, dump_last, busy, done}), 64'(0));
        rst = 1'b0;
        tick();

        // Pattern dump, halted and ready tied high: done at cycle 66 (67).
        applyStimulus();
        runToDone(cyc);
        checkOutput("full dump latency", 64'(cyc), 64'(CSUM_ON ? 67 : 66));
        tick();

        // Pipeline slow to halt: no read, no beat until halted arrives.
        haltLevel = 1'b0;
        halted = 1'b0;
        applyStimulus();
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall while waiting halt", 64'({stallreq, dump_valid}), 64'(2'b10));
            tick();
        end
        haltLevel = 1'b1;
        halted = 1'b1;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!dump_valid && cnt < 20);
        checkOutput("first beat after halted", 64'(cnt), 64'(2));
        runToDone(cyc);
        tick();

        // Back-pressure on r7 and a halt drop while reading r12.
        randomRegs();
        readyHoldAddr = 5'd7;
        readyHoldCnt = 5;
        dropAddr = 5'd12;
        dropCnt = 3;
        applyStimulus();
        runToDone(cyc);
        checkOutput("hold consumed", 64'(readyHoldCnt), 64'(0));
        checkOutput("drop consumed", 64'(dropCnt), 64'(0));
        tick();

        // Abort during the r20 beat, then restart from the first register.
        applyStimulus();
        cnt = 0;
        while (!(dump_valid && dump_addr == 5'd20) && cnt < 200) begin
            tick();
            cnt++;
        end
        checkOutput("reached r20 beat", 64'({dump_valid, dump_addr}), 64'({1'b1, 5'd20}));
        abort = 1'b1;
        dump_ready = 1'b0;
        forceReadyLow = 1'b1;
        doneBefore = doneSeen;
        tick();
        abort = 1'b0;
        forceReadyLow = 1'b0;
        expq.delete();
        doneExpected--;
        checkOutput("after abort", 64'({stallreq, dump_valid, re, busy, done}), 64'(0));
        for (int i = 0; i < 4; i++) tick();
        checkOutput("no done on abort", 64'(doneSeen), 64'(doneBefore));
        applyStimulus();
        runToDone(cyc);
        tick();

        // Reset in the middle of a dump.
        applyStimulus();
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        expq.delete();
        doneExpected--;
        checkOutput("reset mid-dump", 64'({stallreq, re, raddr, dump_valid, dump_addr, dump_data,
                    dump_csum, dump_last, busy, done}), 64'(0));
        rst = 1'b0;
        tick();

        // Random registers with random halted and ready.
        randReady = 1'b1;
        randHalt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            randomRegs();
            applyStimulus();
            runToDone(cyc);
            tick();
        end
        randReady = 1'b0;
        randHalt = 1'b0;
        tick();

        // Single-register range 31..31.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cyc = 1;
        while (!dump_valid1 && cyc < 20) begin
            tick();
            cyc++;
        end
        checkOutput("single beat", 64'({dump_valid1, dump_addr1, dump_data1, dump_last1, dump_csum1}),
                    64'({1'b1, 5'd31, regs[31], !CSUM_ON, 1'b0}));
        if (CSUM_ON) begin
            tick();
            cyc++;
            checkOutput("single csum beat", 64'({dump_valid1, dump_addr1, dump_data1, dump_last1, dump_csum1}),
                        64'({1'b1, 5'd0, regs[31], 1'b1, 1'b1}));
        end
        while (!done1 && cyc < 20) begin
            tick();
            cyc++;
        end
        checkOutput("single done latency", 64'(cyc), 64'(CSUM_ON ? 5 : 4));
        tick();
        checkOutput("single idle", 64'({busy1, stallreq1, re1}), 64'(0));

        tick();
        checkOutput("done count", 64'(doneSeen), 64'(doneExpected));
        checkOutput("queue empty", 64'(expq.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
